iir_mac_accum: RTL and testbench

Downstream stage of the pipelined Booth multiplier in the IIR datapath. It consumes the multiplier's Q4.28 products (valid-pulsed), accumulates NTAPS products per output sample, and applies a per-tap add/subtract sign so the feedback terms are subtracted for direct-form-I biquads. It then rounds and saturates the sum to Q2.14 and emits one output sample per frame.

---
 rtl/iir_pkg.sv | 19 +
 rtl/q_round_sat.sv | 40 ++++
 rtl/iir_mac_accum.sv | 78 +++++++
 tb/tb_iir_mac_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared fixed-point definitions for the IIR datapath.
// Products are Q4.28 and output samples are Q2.14.
package iir_pkg;

  localparam int PROD_W    = 32;
  localparam int PROD_FRAC = 28;
  localparam int Y_W       = 16;
  localparam int Y_FRAC    = 14;

  // Right shift that aligns a product LSB to a sample LSB
  localparam int Q_SHIFT   = PROD_FRAC - Y_FRAC;

  localparam logic [Y_W-1:0] Y_MAX = 16'h7FFF;
  localparam logic [Y_W-1:0] Y_MIN = 16'h8000;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [Y_W-1:0]    sample_t;

endpackage

// File: rtl/q_round_sat.sv
// Combinational Q4.28-aligned accumulator to Q2.14 converter with saturation.
// Build option: ACC_ROUND_EN selects round-half-up; otherwise the value is
// truncated (floor) and there is no adder in this path.
module q_round_sat
  import iir_pkg::*;
#(
  parameter int ACC_W = 35
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [Y_W-1:0]   y,
  output logic                    sat
);

  logic signed [ACC_W-1:0] shifted;
  logic        [ACC_W-Y_W:0] upper;

`ifdef ACC_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (Q_SHIFT - 1));
  logic signed [ACC_W-1:0] rounded;

  assign rounded = acc + HALF;
  assign shifted = rounded >>> Q_SHIFT;
`else
  assign shifted = acc >>> Q_SHIFT;
`endif

  // The sample fits only if every bit from the sample sign bit upward agrees
  assign upper = shifted[ACC_W-1:Y_W-1];

  // Clip to the Q2.14 limits when the shifted value does not fit in 16 bits
  always_comb begin
    y   = shifted[Y_W-1:0];
    sat = 1'b0;
    if (!(&upper) && (|upper)) begin
      sat = 1'b1;
      y   = shifted[ACC_W-1] ? Y_MIN : Y_MAX;
    end
  end

endmodule

// File: rtl/iir_mac_accum.sv
// Per-sample accumulator behind the Booth multiplier: sums NTAPS signed
// products (feedback taps subtracted per SUB_MASK), then rounds/saturates to
// Q2.14 and pulses y_valid once per frame.
// Build option: ACC_ROUND_EN enables round-half-up in the output conversion.
module iir_mac_accum
  import iir_pkg::*;
#(
  parameter int               NTAPS    = 5,
  parameter logic [NTAPS-1:0] SUB_MASK = 5'b11000,
  parameter int               GUARD    = 3,
  localparam int              ACC_W    = PROD_W + GUARD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     prod_valid,
  input  logic                     clr,
  output logic signed [Y_W-1:0]    y,
  output logic                     y_valid,
  output logic                     sat,
  output logic        [2:0]        tap_cnt,
  output logic                     busy
);

  // Mask widened to the full tap-counter range so indexing is always in range
  localparam logic [7:0] MASK8    = 8'(SUB_MASK);
  localparam logic [2:0] LAST_TAP = 3'(NTAPS - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic signed [Y_W-1:0]   rs_y;
  logic                    rs_sat;

  // Negating at ACC_W width keeps -(0x8000_0000) exact
  assign ext  = {{GUARD{prod[PROD_W-1]}}, prod};
  assign term = MASK8[tap_cnt] ? -ext : ext;
  assign sum  = acc + term;
  assign busy = (tap_cnt != 3'd0);

  q_round_sat #(
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc (sum),
    .y   (rs_y),
    .sat (rs_sat)
  );

  // Accumulate one product per cycle; on the last tap register the result and restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      tap_cnt <= 3'd0;
      y       <= '0;
      sat     <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (clr) begin
        acc     <= '0;
        tap_cnt <= 3'd0;
      end else if (prod_valid) begin
        if (tap_cnt == LAST_TAP) begin
          y       <= rs_y;
          sat     <= rs_sat;
          y_valid <= 1'b1;
          acc     <= '0;
          tap_cnt <= 3'd0;
        end else begin
          acc     <= sum;
          tap_cnt <= tap_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_mac_accum.sv
// Directed bench for iir_mac_accum: a table of full frames with hand-computed
// Q2.14 results, plus sequences for back-to-back frames, clr and mid-frame reset.
// Expected values for the rounding cases follow ACC_ROUND_EN.
module tb_iir_mac_accum;

  typedef struct {
    logic [4:0][31:0] p;
    logic [15:0]      ey;
    logic             esat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] prod;
  logic        prod_valid;
  logic        clr;
  logic [15:0] y;
  logic        y_valid;
  logic        sat;
  logic [2:0]  tap_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vec_t vecs[12];

  iir_mac_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod       (prod),
    .prod_valid (prod_valid),
    .clr        (clr),
    .y          (y),
    .y_valid    (y_valid),
    .sat        (sat),
    .tap_cnt    (tap_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Waits for the falling edge, so outputs are stable, then drives new inputs
  task automatic applyStimulus(input logic [31:0] p, input logic v, input logic c);
    @(negedge clk);
    prod       = p;
    prod_valid = v;
    clr        = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [31:0] e,
                              input logic [15:0] ey, input logic es);
    vec_t r;
    r.p[0] = a; r.p[1] = b; r.p[2] = c; r.p[3] = d; r.p[4] = e;
    r.ey   = ey;
    r.esat = es;
    return r;
  endfunction

  // Five back-to-back products, then check the one-cycle result pulse and hold
  task automatic runFrame(input logic [4:0][31:0] p, input logic [15:0] ey,
                          input logic es, input string name);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(p[i], 1'b1, 1'b0);
      if (i > 0) checkOutput($sformatf("%s.early%0d", name, i), y_valid, 0);
    end
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput({name, ".valid"}, y_valid, 1);
    checkOutput({name, ".y"}, y, ey);
    checkOutput({name, ".sat"}, sat, es);
    checkOutput({name, ".busy"}, busy, 0);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput({name, ".pulse"}, y_valid, 0);
    checkOutput({name, ".yhold"}, y, ey);
  endtask

  initial begin
    int hits;
    int first;
    int second;
    logic [15:0] seen_y;

    vecs[0]  = mk(32'h04000000, 32'h04000000, 32'h04000000, 32'h04000000, 32'h04000000, 16'h1000, 1'b0);
    vecs[1]  = mk(32'h70000000, 32'h70000000, 32'h70000000, 32'h0, 32'h0, 16'h7FFF, 1'b1);
    vecs[2]  = mk(32'h0, 32'h0, 32'h0, 32'h70000000, 32'h70000000, 16'h8000, 1'b1);
`ifdef ACC_ROUND_EN
    vecs[3]  = mk(32'h00002000, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0001, 1'b0);
    vecs[4]  = mk(32'h0, 32'h0, 32'h0, 32'h00002000, 32'h0, 16'h0000, 1'b0);
`else
    vecs[3]  = mk(32'h00002000, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0000, 1'b0);
    vecs[4]  = mk(32'h0, 32'h0, 32'h0, 32'h00002000, 32'h0, 16'hFFFF, 1'b0);
`endif
    vecs[5]  = mk(32'h10000000, 32'h08000000, 32'h0, 32'h04000000, 32'h0, 16'h5000, 1'b0);
    vecs[6]  = mk(32'h80000000, 32'h0, 32'h0, 32'h80000000, 32'h0, 16'h0000, 1'b0);
    vecs[7]  = mk(32'hF0000000, 32'h0, 32'h0, 32'h0, 32'h0, 16'hC000, 1'b0);
    vecs[8]  = mk(32'h1FFFC000, 32'h0, 32'h0, 32'h0, 32'h0, 16'h7FFF, 1'b0);
    vecs[9]  = mk(32'h20000000, 32'h0, 32'h0, 32'h0, 32'h0, 16'h7FFF, 1'b1);
    vecs[10] = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'hF0000000, 16'h4000, 1'b0);
    vecs[11] = mk(32'hE0000000, 32'h0, 32'h0, 32'h0, 32'h0, 16'h8000, 1'b0);

    // Reset state
    rst_n      = 1'b0;
    prod       = 32'h0;
    prod_valid = 1'b0;
    clr        = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.y", y, 0);
    checkOutput("reset.y_valid", y_valid, 0);
    checkOutput("reset.sat", sat, 0);
    checkOutput("reset.tap_cnt", tap_cnt, 0);
    checkOutput("reset.busy", busy, 0);
    rst_n = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0);

    // Tap counter progress inside a frame
    applyStimulus(32'h04000000, 1'b1, 1'b0);
    applyStimulus(32'h04000000, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("tapcnt.two", tap_cnt, 2);
    checkOutput("tapcnt.busy", busy, 1);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("tapcnt.hold", tap_cnt, 2);
    applyStimulus(32'h04000000, 1'b1, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("tapcnt.clr", tap_cnt, 0);

    // Table of full frames
    for (int i = 0; i < 12; i++) begin
      runFrame(vecs[i].p, vecs[i].ey, vecs[i].esat, $sformatf("vec%0d", i));
    end

    // Abort a partial frame with clr while a product is presented
    hits   = 0;
    seen_y = 16'h0;
    for (int j = 0; j < 3; j++) applyStimulus(32'h04000000, 1'b1, 1'b0);
    applyStimulus(32'h04000000, 1'b1, 1'b1);
    for (int j = 0; j < 7; j++) begin
      if (j < 5) applyStimulus(32'h04000000, 1'b1, 1'b0);
      else       applyStimulus(32'h0, 1'b0, 1'b0);
      if (j == 0) checkOutput("clr.tap_cnt", tap_cnt, 0);
      if (y_valid) begin
        hits++;
        seen_y = y;
      end
    end
    checkOutput("clr.pulses", hits, 1);
    checkOutput("clr.y", seen_y, 16'h1000);

    // clr on the final tap suppresses the result and holds y/sat
    hits = 0;
    for (int j = 0; j < 4; j++) applyStimulus(32'h70000000, 1'b1, 1'b0);
    applyStimulus(32'h70000000, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(32'h0, 1'b0, 1'b0);
      if (y_valid) hits++;
    end
    checkOutput("clrlast.pulses", hits, 0);
    checkOutput("clrlast.y", y, 16'h1000);
    checkOutput("clrlast.sat", sat, 0);
    checkOutput("clrlast.tap_cnt", tap_cnt, 0);

    // Ten consecutive products give two pulses five cycles apart
    hits   = 0;
    first  = -1;
    second = -1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c < 10) ? 32'h04000000 : 32'h0, (c < 10), 1'b0);
      if (y_valid) begin
        hits++;
        if (hits == 1) first = c;
        else second = c;
        checkOutput($sformatf("b2b.y%0d", hits), y, 16'h1000);
      end
    end
    checkOutput("b2b.pulses", hits, 2);
    checkOutput("b2b.first", first, 5);
    checkOutput("b2b.spacing", second - first, 5);

    // Asynchronous reset mid-frame discards the partial sum
    for (int j = 0; j < 4; j++) applyStimulus(32'h04000000, 1'b1, 1'b0);
    @(negedge clk);
    prod_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("midrst.y", y, 0);
    checkOutput("midrst.y_valid", y_valid, 0);
    checkOutput("midrst.sat", sat, 0);
    checkOutput("midrst.tap_cnt", tap_cnt, 0);
    checkOutput("midrst.busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hits  = 0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(32'h0, 1'b0, 1'b0);
      if (y_valid) hits++;
    end
    checkOutput("midrst.pulses", hits, 0);
    checkOutput("midrst.y_after", y, 0);
    runFrame(vecs[0].p, 16'h1000, 1'b0, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
